// File: rtl/sdram_arbiter_if.sv
// sdram_arbiter_if: bundles both requester ports and the SDRAM controller
// command port of the arbiter.
//   slave  modport: the arbiter (consumes requests, drives the memory command)
//   master modport: the surrounding system (requesters + controller)
// Signal names keep the arbiter-relative _i/_o suffixes.
interface sdram_arbiter_if #(
  parameter int ADDR_W = 24
);
  // Port 0: video scan-out fetcher
  logic              req0_valid_i;
  logic              req0_we_i;
  logic [ADDR_W-1:0] req0_addr_i;
  logic [31:0]       req0_wdata_i;
  logic [3:0]        req0_wmask_i;
  logic              req0_ready_o;
  logic              req0_done_o;
  logic [31:0]       req0_rdata_o;
  // Port 1: CPU data bus
  logic              req1_valid_i;
  logic              req1_we_i;
  logic [ADDR_W-1:0] req1_addr_i;
  logic [31:0]       req1_wdata_i;
  logic [3:0]        req1_wmask_i;
  logic              req1_ready_o;
  logic              req1_done_o;
  logic [31:0]       req1_rdata_o;
  // SDRAM controller command port
  logic              mem_valid_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [31:0]       mem_wdata_o;
  logic [3:0]        mem_wmask_o;
  logic              mem_ready_i;
  logic              mem_rvalid_i;
  logic [31:0]       mem_rdata_i;

  modport slave (
    input  req0_valid_i, req0_we_i, req0_addr_i, req0_wdata_i, req0_wmask_i,
    output req0_ready_o, req0_done_o, req0_rdata_o,
    input  req1_valid_i, req1_we_i, req1_addr_i, req1_wdata_i, req1_wmask_i,
    output req1_ready_o, req1_done_o, req1_rdata_o,
    output mem_valid_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o,
    input  mem_ready_i, mem_rvalid_i, mem_rdata_i
  );

  modport master (
    output req0_valid_i, req0_we_i, req0_addr_i, req0_wdata_i, req0_wmask_i,
    input  req0_ready_o, req0_done_o, req0_rdata_o,
    output req1_valid_i, req1_we_i, req1_addr_i, req1_wdata_i, req1_wmask_i,
    input  req1_ready_o, req1_done_o, req1_rdata_o,
    input  mem_valid_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o,
    output mem_ready_i, mem_rvalid_i, mem_rdata_i
  );
endinterface

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: shares the single SDRAM controller command port between the
// video fetcher (port 0) and the CPU (port 1). One transaction in flight at a
// time; the granted command is registered, completion and read data are
// routed back to the granted port only.
//
// Ports:
//   clk      system clock, rising edge
//   reset_i  synchronous active-high reset
//   bus      sdram_arbiter_if.slave: both requester ports + controller port
//
// Parameters:
//   ADDR_W      word address width
//   MAX_STREAK  consecutive port-0 grants allowed while port 1 waits (aging)
//
// Build option: define SDRAM_ARB_AGING_EN to let a waiting port 1 win after
// MAX_STREAK consecutive port-0 grants. Undefined: strict port-0 priority.
module sdram_arbiter #(
  parameter int ADDR_W     = 24,
  parameter int MAX_STREAK = 4
) (
  input  logic              clk,
  input  logic              reset_i,
  sdram_arbiter_if.slave    bus
);

  // A zero streak limit would make port 0 lose every contested grant.
  if (MAX_STREAK < 1) begin : g_bad_max_streak
    $error("MAX_STREAK must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              gnt_q, gnt_d;
  logic              mem_valid_q, mem_valid_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_wmask_q, mem_wmask_d;
  logic              done0_q, done0_d;
  logic              done1_q, done1_d;
  logic [31:0]       rdata0_q, rdata0_d;
  logic [31:0]       rdata1_q, rdata1_d;
  logic              ready0, ready1;
  logic              aging_hit;
  logic              pick1;

`ifdef SDRAM_ARB_AGING_EN
  localparam int                  STREAK_W   = $clog2(MAX_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_STREAK);

  logic [STREAK_W-1:0] streak_q, streak_d;

  assign aging_hit = bus.req0_valid_i && bus.req1_valid_i && (streak_q == STREAK_MAX);
`else
  assign aging_hit = 1'b0;
`endif

  // Port 1 wins when it is alone, or when aging forces a turn.
  assign pick1 = bus.req1_valid_i && (!bus.req0_valid_i || aging_hit);

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    mem_valid_d = mem_valid_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wmask_d = mem_wmask_q;
    done0_d     = 1'b0;
    done1_d     = 1'b0;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    ready0      = 1'b0;
    ready1      = 1'b0;
`ifdef SDRAM_ARB_AGING_EN
    streak_d    = streak_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.req0_valid_i || bus.req1_valid_i) begin
          mem_valid_d = 1'b1;
          state_d     = ISSUE;
          if (pick1) begin
            ready1      = 1'b1;
            gnt_d       = 1'b1;
            mem_we_d    = bus.req1_we_i;
            mem_addr_d  = bus.req1_addr_i;
            mem_wdata_d = bus.req1_wdata_i;
            mem_wmask_d = bus.req1_wmask_i;
          end else begin
            ready0      = 1'b1;
            gnt_d       = 1'b0;
            mem_we_d    = bus.req0_we_i;
            mem_addr_d  = bus.req0_addr_i;
            mem_wdata_d = bus.req0_wdata_i;
            mem_wmask_d = bus.req0_wmask_i;
          end
`ifdef SDRAM_ARB_AGING_EN
          // Only port-0 wins that leave port 1 waiting extend the streak.
          if (pick1 || !bus.req1_valid_i) begin
            streak_d = '0;
          end else if (streak_q != STREAK_MAX) begin
            streak_d = streak_q + STREAK_W'(1);
          end
`endif
        end
      end

      ISSUE: begin
        if (bus.mem_ready_i) begin
          mem_valid_d = 1'b0;
          if (mem_we_q) begin
            done0_d = !gnt_q;
            done1_d = gnt_q;
            state_d = IDLE;
          end else begin
            state_d = WAIT_RD;
          end
        end
      end

      WAIT_RD: begin
        if (bus.mem_rvalid_i) begin
          if (gnt_q) begin
            rdata1_d = bus.mem_rdata_i;
          end else begin
            rdata0_d = bus.mem_rdata_i;
          end
          done0_d = !gnt_q;
          done1_d = gnt_q;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      state_q     <= IDLE;
      gnt_q       <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wmask_q <= '0;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
`ifdef SDRAM_ARB_AGING_EN
      streak_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      mem_valid_q <= mem_valid_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wmask_q <= mem_wmask_d;
      done0_q     <= done0_d;
      done1_q     <= done1_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
`ifdef SDRAM_ARB_AGING_EN
      streak_q    <= streak_d;
`endif
    end
  end

  assign bus.req0_ready_o = ready0;
  assign bus.req1_ready_o = ready1;
  assign bus.req0_done_o  = done0_q;
  assign bus.req1_done_o  = done1_q;
  assign bus.req0_rdata_o = rdata0_q;
  assign bus.req1_rdata_o = rdata1_q;
  assign bus.mem_valid_o  = mem_valid_q;
  assign bus.mem_we_o     = mem_we_q;
  assign bus.mem_addr_o   = mem_addr_q;
  assign bus.mem_wdata_o  = mem_wdata_q;
  assign bus.mem_wmask_o  = mem_wmask_q;

endmodule
